// File: rtl/bcd2hex.sv
// bcd2hex: sequential four-digit packed BCD to unsigned binary converter.
// A conversion takes 16 shift cycles plus one finish cycle (reverse double
// dabble). Optional macro BCD2HEX_DIGIT_CHECK_EN adds detection of nibbles
// above 9: such inputs finish with err=1 and HexOut=16'hFFFF.
module bcd2hex (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        start,
  input  logic [15:0] BCD_in,
  output logic [15:0] HexOut,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [4:0]  r_cnt;
  logic [4:0]  w_cnt_nxt;
  logic [15:0] r_digit;
  logic [15:0] w_digit_nxt;
  logic [15:0] r_bin;
  logic [15:0] w_bin_nxt;
  logic [15:0] w_hex_nxt;
  logic        w_busy_nxt;
  logic        w_done_nxt;
  logic [31:0] w_shift;

  // After each right shift, a digit nibble holding 8..15 carried a half-ten
  // in from the digit above; subtracting 3 restores it to base ten.
  function automatic logic [15:0] dabble_adj(input logic [15:0] d);
    logic [15:0] res;
    res = d;
    for (int k = 0; k < 4; k++) begin
      if (d[k*4 +: 4] >= 4'd8) begin
        res[k*4 +: 4] = d[k*4 +: 4] - 4'd3;
      end else begin
        res[k*4 +: 4] = d[k*4 +: 4];
      end
    end
    return res;
  endfunction

`ifdef BCD2HEX_DIGIT_CHECK_EN
  logic r_bad;
  logic w_bad_nxt;
  logic w_err_nxt;

  // True when any of the four nibbles is not a decimal digit.
  function automatic logic has_bad_digit(input logic [15:0] d);
    logic bad;
    bad = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (d[k*4 +: 4] > 4'd9) begin
        bad = 1'b1;
      end else begin
        bad = bad;
      end
    end
    return bad;
  endfunction
`endif

  assign w_shift = {r_digit, r_bin} >> 1;

  // Next-state and next-output decode for the IDLE/SHIFT/FINISH sequence.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_digit_nxt = r_digit;
    w_bin_nxt   = r_bin;
    w_hex_nxt   = HexOut;
    w_busy_nxt  = busy;
    w_done_nxt  = 1'b0;
`ifdef BCD2HEX_DIGIT_CHECK_EN
    w_bad_nxt   = r_bad;
    w_err_nxt   = err;
`endif
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = SHIFT;
          w_digit_nxt = BCD_in;
          w_bin_nxt   = 16'd0;
          w_cnt_nxt   = 5'd0;
          w_busy_nxt  = 1'b1;
`ifdef BCD2HEX_DIGIT_CHECK_EN
          w_bad_nxt   = has_bad_digit(BCD_in);
`endif
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SHIFT: begin
        w_digit_nxt = dabble_adj(w_shift[31:16]);
        w_bin_nxt   = w_shift[15:0];
        w_cnt_nxt   = r_cnt + 5'd1;
        if (r_cnt == 5'd15) begin
          w_state_nxt = FINISH;
        end else begin
          w_state_nxt = SHIFT;
        end
      end
      FINISH: begin
`ifdef BCD2HEX_DIGIT_CHECK_EN
        w_hex_nxt = r_bad ? 16'hFFFF : r_bin;
        w_err_nxt = r_bad;
`else
        w_hex_nxt = r_bin;
`endif
        w_done_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers with synchronous active-low reset.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 5'd0;
      r_digit <= 16'd0;
      r_bin   <= 16'd0;
      HexOut  <= 16'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_digit <= w_digit_nxt;
      r_bin   <= w_bin_nxt;
      HexOut  <= w_hex_nxt;
      busy    <= w_busy_nxt;
      done    <= w_done_nxt;
    end
  end

`ifdef BCD2HEX_DIGIT_CHECK_EN
  // Invalid-digit flag captured at load and published at finish.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_bad <= 1'b0;
      err   <= 1'b0;
    end else begin
      r_bad <= w_bad_nxt;
      err   <= w_err_nxt;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd2hex.sv
// Self-checking bench for bcd2hex: directed cases plus randomized conversions
// compared against a decimal-arithmetic reference model.
module tb_bcd2hex;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        start;
  logic [15:0] BCD_in;
  logic [15:0] HexOut;
  logic        busy;
  logic        done;
  logic        err;

  int n_chk  = 0;
  int n_pass = 0;

  bcd2hex dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .start    (start),
    .BCD_in   (BCD_in),
    .HexOut   (HexOut),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Decimal value of the four digits; chk=0 when the result is unspecified.
  function automatic void ref_model(input logic [15:0] bcd, output logic [15:0] h,
                                    output logic e, output bit chk);
    int v;
    int d;
    bit bad;
    v   = 0;
    bad = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      d = (int'(bcd) >> (4 * k)) & 15;
      if (d > 9) bad = 1'b1;
      v = v * 10 + d;
    end
`ifdef BCD2HEX_DIGIT_CHECK_EN
    h   = bad ? 16'hFFFF : 16'(v);
    e   = bad;
    chk = 1'b1;
`else
    h   = 16'(v);
    e   = 1'b0;
    chk = !bad;
`endif
  endfunction

  // One conversion; ends #1 after edge 18. With chain=1 the next conversion
  // (operand nxt) is started at edge 18, so the following call uses preloaded=1.
  task automatic run_conv(input logic [15:0] bcd, input bit preloaded,
                          input bit chain, input logic [15:0] nxt);
    logic [15:0] e_hex;
    logic        e_err;
    bit          e_chk;
    ref_model(bcd, e_hex, e_err, e_chk);
    if (!preloaded) begin
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      start     = 1'b1;
      BCD_in    = bcd;
      @(posedge sys_clk); #1;
      check("load_busy", busy, 32'd1);
      check("load_done", done, 32'd0);
    end
    for (int e = 1; e <= 16; e++) begin
      @(negedge sys_clk);
      start  = 1'($urandom_range(0, 1));
      BCD_in = 16'($urandom);
      @(posedge sys_clk); #1;
      check("shift_busy", busy, 32'd1);
      check("shift_done", done, 32'd0);
    end
    @(negedge sys_clk);
    start  = 1'($urandom_range(0, 1));
    BCD_in = 16'($urandom);
    @(posedge sys_clk); #1;
    check("fin_done", done, 32'd1);
    check("fin_busy", busy, 32'd0);
    if (e_chk) check("fin_hex", HexOut, 32'(e_hex));
    check("fin_err", err, 32'(e_err));
    @(negedge sys_clk);
    start  = chain;
    BCD_in = chain ? nxt : 16'($urandom);
    @(posedge sys_clk); #1;
    check("post_done", done, 32'd0);
    check("post_busy", busy, 32'(chain));
    if (e_chk) check("post_hex_hold", HexOut, 32'(e_hex));
    check("post_err_hold", err, 32'(e_err));
  endtask

  initial begin
    logic [15:0] v;
    logic [15:0] nv;
    bit          ch;
    bit          pre;
    sys_rst_n = 1'b0;
    start     = 1'b0;
    BCD_in    = 16'd0;
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_hex", HexOut, 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_done", done, 32'd0);
    check("rst_err", err, 32'd0);

    // Directed values, including chained 0x0042 -> 0x0777.
    run_conv(16'h1234, 1'b0, 1'b0, 16'h0000);
    run_conv(16'h9999, 1'b0, 1'b0, 16'h0000);
    run_conv(16'h0000, 1'b0, 1'b0, 16'h0000);
    run_conv(16'h0042, 1'b0, 1'b1, 16'h0777);
    run_conv(16'h0777, 1'b1, 1'b0, 16'h0000);
    run_conv(16'h12A4, 1'b0, 1'b0, 16'h0000);
    run_conv(16'h0010, 1'b0, 1'b0, 16'h0000);

    // Reset at edge 8 aborts a conversion; reset beats a simultaneous start.
    @(negedge sys_clk);
    start  = 1'b1;
    BCD_in = 16'h5678;
    @(posedge sys_clk);
    for (int e = 1; e <= 7; e++) begin
      @(negedge sys_clk);
      start = 1'b0;
      @(posedge sys_clk);
    end
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    @(posedge sys_clk); #1;
    check("abort_busy", busy, 32'd0);
    check("abort_hex", HexOut, 32'd0);
    check("abort_done", done, 32'd0);
    check("abort_err", err, 32'd0);
    @(negedge sys_clk);
    start = 1'b1;
    @(posedge sys_clk); #1;
    check("rst_prio_busy", busy, 32'd0);
    check("rst_prio_hex", HexOut, 32'd0);
    run_conv(16'h5678, 1'b0, 1'b0, 16'h0000);

    // Randomized conversions, mostly valid digits, some chained.
    pre = 1'b0;
    v   = 16'h0000;
    for (int n = 0; n < 24; n++) begin
      if (!pre) begin
        if ($urandom_range(0, 4) == 0) begin
          v = 16'($urandom);
        end else begin
          v = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
               4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        end
      end
      nv = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
            4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      ch = (n < 23) ? 1'($urandom_range(0, 1)) : 1'b0;
      run_conv(v, pre, ch, nv);
      pre = ch;
      v   = nv;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
